sym_vn_lut_loader: RTL and testbench



---
 rtl/sym_vn_pkg.sv | 33 +++
 rtl/sym_vn_page_counter.sv | 39 +++
 rtl/sym_vn_lut_loader.sv | 189 ++++++++++++++++++
 tb/tb_sym_vn_lut_loader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sym_vn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sym_vn_pkg
// Brief    : Shared loader FSM encoding and LUT page geometry helpers.
// Revision : 1.0 - initial release
// ============================================================================
package sym_vn_pkg;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FILL0 = 3'd1;
    localparam logic [2:0] c_ST_FILL1 = 3'd2;
    localparam logic [2:0] c_ST_CHECK = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = c_ST_IDLE,
        ST_FILL0 = c_ST_FILL0,
        ST_FILL1 = c_ST_FILL1,
        ST_CHECK = c_ST_CHECK,
        ST_DONE  = c_ST_DONE
    } loader_state_t;

    // Page address width: entry address minus the frame-half select bits.
    function automatic int calc_pw(input int entry_addr, input int multi_frame_num);
        return entry_addr - $clog2(multi_frame_num);
    endfunction

    function automatic int calc_page_num(input int pw);
        return 1 << pw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sym_vn_page_counter.sv
`default_nettype none
// ============================================================================
// Module   : sym_vn_page_counter
// Brief    : PW-bit page counter with clear, increment and last-page flag.
// Revision : 1.0 - initial release
// ============================================================================
module sym_vn_page_counter
    import sym_vn_pkg::*;
#(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [PW-1:0] o_count,
    output logic          o_last
);

    localparam logic [PW-1:0] c_LAST = PW'(calc_page_num(PW) - 1);

    logic [PW-1:0] r_count;

    // Natural PW-bit wrap returns the counter to 0 after the last page.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/sym_vn_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : sym_vn_lut_loader
// Brief    : Pairs a stream of LUT entries into bank0/bank1 page writes for
//            one frame half of the symmetric VN LUT.
// Options  : SYM_VN_LOADER_CHKSUM_EN - trailing XOR checksum beat + load_err.
// Revision : 1.0 - initial release
// ============================================================================
module sym_vn_lut_loader
    import sym_vn_pkg::*;
#(
    parameter int QUAN_SIZE       = 3,
    parameter int LUT_PORT_SIZE   = 3,
    parameter int ENTRY_ADDR      = 5,
    parameter int MULTI_FRAME_NUM = 2,
    localparam int PW             = calc_pw(ENTRY_ADDR, MULTI_FRAME_NUM)
) (
    input  logic                     write_clk,
    input  logic                     rstn,
    input  logic                     load_start,
    input  logic                     load_offset,
    input  logic [LUT_PORT_SIZE-1:0] entry_in,
    input  logic                     entry_valid,
    output logic                     entry_ready,
    output logic                     load_busy,
    output logic                     load_done,
    output logic                     load_err,
    output logic [LUT_PORT_SIZE-1:0] lut_in_bank0,
    output logic [LUT_PORT_SIZE-1:0] lut_in_bank1,
    output logic [PW-1:0]            page_write_addr,
    output logic                     write_addr_offset,
    output logic                     we
);

    if (QUAN_SIZE > LUT_PORT_SIZE) begin : g_cfg_check
        $error("sym_vn_lut_loader: QUAN_SIZE wider than LUT_PORT_SIZE");
    end

`ifdef SYM_VN_LOADER_CHKSUM_EN
    localparam loader_state_t c_AFTER_LAST = ST_CHECK;
`else
    localparam loader_state_t c_AFTER_LAST = ST_DONE;
`endif

    loader_state_t            r_state;
    loader_state_t            w_next_state;
    logic                     w_ready;
    logic                     w_hs;
    logic                     w_start_acc;
    logic                     w_wr;
    logic                     w_last;
    logic [PW-1:0]            w_count;

    logic [LUT_PORT_SIZE-1:0] r_hold;
    logic [LUT_PORT_SIZE-1:0] r_bank0;
    logic [LUT_PORT_SIZE-1:0] r_bank1;
    logic [PW-1:0]            r_page;
    logic                     r_offset;
    logic                     r_we;
    logic                     r_busy;
    logic                     r_done;

    assign w_hs        = entry_valid & w_ready;
    assign w_start_acc = (r_state == ST_IDLE) & load_start;
    assign w_wr        = (r_state == ST_FILL1) & w_hs;

    sym_vn_page_counter #(
        .PW      (PW)
    ) u_page_counter (
        .clk     (write_clk),
        .rstn    (rstn),
        .i_clr   (w_start_acc),
        .i_inc   (w_wr),
        .o_count (w_count),
        .o_last  (w_last)
    );

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ready      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_start) begin
                    w_next_state = ST_FILL0;
                end
            end
            ST_FILL0: begin
                w_ready = 1'b1;
                if (entry_valid) begin
                    w_next_state = ST_FILL1;
                end
            end
            ST_FILL1: begin
                w_ready = 1'b1;
                if (entry_valid) begin
                    w_next_state = w_last ? c_AFTER_LAST : ST_FILL0;
                end
            end
`ifdef SYM_VN_LOADER_CHKSUM_EN
            ST_CHECK: begin
                w_ready = 1'b1;
                if (entry_valid) begin
                    w_next_state = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Write-port outputs only move on a FILL1 handshake, so data and address
    // are stable for the single cycle we is asserted.
    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_hold   <= '0;
            r_bank0  <= '0;
            r_bank1  <= '0;
            r_page   <= '0;
            r_offset <= 1'b0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_we   <= w_wr;
            r_done <= (r_state == ST_DONE);
            if (w_start_acc) begin
                r_offset <= load_offset;
                r_busy   <= 1'b1;
            end else if (r_state == ST_DONE) begin
                r_busy   <= 1'b0;
            end
            if ((r_state == ST_FILL0) && w_hs) begin
                r_hold <= entry_in;
            end
            if (w_wr) begin
                r_bank0 <= r_hold;
                r_bank1 <= entry_in;
                r_page  <= w_count;
            end
        end
    end

`ifdef SYM_VN_LOADER_CHKSUM_EN
    logic [LUT_PORT_SIZE-1:0] r_xor;
    logic                     r_err;

    always_ff @(posedge write_clk) begin
        if (!rstn) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (w_start_acc) begin
            r_xor <= '0;
            r_err <= 1'b0;
        end else if (((r_state == ST_FILL0) || (r_state == ST_FILL1)) && w_hs) begin
            r_xor <= r_xor ^ entry_in;
        end else if ((r_state == ST_CHECK) && w_hs) begin
            r_err <= (entry_in != r_xor);
        end
    end

    assign load_err = r_err;
`else
    assign load_err = 1'b0;
`endif

    assign entry_ready       = w_ready;
    assign load_busy         = r_busy;
    assign load_done         = r_done;
    assign lut_in_bank0      = r_bank0;
    assign lut_in_bank1      = r_bank1;
    assign page_write_addr   = r_page;
    assign write_addr_offset = r_offset;
    assign we                = r_we;

endmodule
`default_nettype wire

// File: tb/tb_sym_vn_lut_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_sym_vn_lut_loader
// Brief    : Directed self-checking bench for the VN LUT loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sym_vn_lut_loader;

    logic       write_clk = 1'b0;
    logic       rstn = 1'b0;
    logic       load_start = 1'b0;
    logic       load_offset = 1'b0;
    logic [2:0] entry_in = 3'd0;
    logic       entry_valid = 1'b0;
    logic       entry_ready;
    logic       load_busy;
    logic       load_done;
    logic       load_err;
    logic [2:0] lut_in_bank0;
    logic [2:0] lut_in_bank1;
    logic [3:0] page_write_addr;
    logic       write_addr_offset;
    logic       we;

    int n_tests = 0;
    int n_fail  = 0;

    sym_vn_lut_loader dut (
        .write_clk         (write_clk),
        .rstn              (rstn),
        .load_start        (load_start),
        .load_offset       (load_offset),
        .entry_in          (entry_in),
        .entry_valid       (entry_valid),
        .entry_ready       (entry_ready),
        .load_busy         (load_busy),
        .load_done         (load_done),
        .load_err          (load_err),
        .lut_in_bank0      (lut_in_bank0),
        .lut_in_bank1      (lut_in_bank1),
        .page_write_addr   (page_write_addr),
        .write_addr_offset (write_addr_offset),
        .we                (we)
    );

    always #5 write_clk = ~write_clk;

    // Write/done monitor, sampled on the falling edge.
    int          cyc = 0;
    logic [31:0] wr_q[$];
    int          n_done = 0;
    int          n_consec = 0;
    int          last_we_cyc = 0;
    int          done_cyc = 0;
    logic        prev_we = 1'b0;

    always @(posedge write_clk) cyc <= cyc + 1;

    always @(negedge write_clk) begin
        if (we) begin
            wr_q.push_back({21'd0, page_write_addr, lut_in_bank0, lut_in_bank1, write_addr_offset});
            last_we_cyc = cyc;
            if (prev_we) n_consec++;
        end
        if (load_done) begin
            n_done++;
            done_cyc = cyc;
        end
        prev_we = we;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge write_clk);
        #1;
    endtask

    function automatic logic [2:0] pat(input int sel, input int k);
        case (sel)
            0:       pat = 3'(k % 8);
            1:       pat = 3'((k * 3 + 1) % 8);
            default: pat = 3'(7 - (k % 8));
        endcase
    endfunction

    task automatic clear_mon();
        wr_q.delete();
        n_done   = 0;
        n_consec = 0;
    endtask

    task automatic pulse_start(input logic off);
        load_start  = 1'b1;
        load_offset = off;
        step();
        load_start  = 1'b0;
    endtask

    task automatic send_entry(input logic [2:0] v, input int gap);
        bit hs;
        bit ok;
        entry_valid = 1'b0;
        repeat (gap) step();
        entry_in    = v;
        entry_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            hs = entry_ready;
            step();
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        entry_valid = 1'b0;
        chk("handshake_timeout", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_table(input int sel, input int maxgap, input int first, input int last);
        for (int k = first; k < last; k++)
            send_entry(pat(sel, k), (maxgap == 0) ? 0 : $urandom_range(0, maxgap));
    endtask

    function automatic logic [2:0] table_xor(input int sel);
        logic [2:0] x;
        x = 3'd0;
        for (int k = 0; k < 32; k++) x = x ^ pat(sel, k);
        return x;
    endfunction

    // Sends the optional checksum beat, waits for load_done and checks the
    // cycle-level completion behaviour.
    task automatic finish_load(input string tag, input int sel, input bit bad_sum);
        bit seen;
`ifdef SYM_VN_LOADER_CHKSUM_EN
        send_entry(table_xor(sel) ^ {2'b00, bad_sum}, 0);
`endif
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (load_done) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, "_busy_at_done"}, {31'd0, load_busy}, 32'd0);
`ifdef SYM_VN_LOADER_CHKSUM_EN
        chk({tag, "_err"}, {31'd0, load_err}, {31'd0, bad_sum});
`else
        chk({tag, "_err"}, {31'd0, load_err}, 32'd0);
`endif
        step();
        chk({tag, "_done_pulse"}, {31'd0, load_done}, 32'd0);
    endtask

    task automatic check_writes(input string tag, input int sel, input logic off);
        logic [31:0] exp;
        chk({tag, "_we_count"}, wr_q.size(), 32'd16);
        for (int p = 0; p < 16 && p < wr_q.size(); p++) begin
            exp = {21'd0, 4'(p), pat(sel, 2 * p), pat(sel, 2 * p + 1), off};
            chk($sformatf("%s_page%0d", tag, p), wr_q[p], exp);
        end
        chk({tag, "_consec_we"}, n_consec, 32'd0);
        chk({tag, "_done_count"}, n_done, 32'd1);
`ifdef SYM_VN_LOADER_CHKSUM_EN
        chk({tag, "_done_latency"}, done_cyc - last_we_cyc, 32'd2);
`else
        chk({tag, "_done_latency"}, done_cyc - last_we_cyc, 32'd1);
`endif
    endtask

    initial begin
        // Reset state
        rstn = 1'b0;
        step();
        step();
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_busy", {31'd0, load_busy}, 32'd0);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_err", {31'd0, load_err}, 32'd0);
        chk("rst_ready", {31'd0, entry_ready}, 32'd0);
        chk("rst_wdata", {21'd0, page_write_addr, lut_in_bank0, lut_in_bank1, write_addr_offset}, 32'd0);
        rstn = 1'b1;
        step();
        chk("idle_ready", {31'd0, entry_ready}, 32'd0);

        // Full load, offset 0, no gaps
        clear_mon();
        pulse_start(1'b0);
        chk("t1_busy", {31'd0, load_busy}, 32'd1);
        chk("t1_ready", {31'd0, entry_ready}, 32'd1);
        send_table(0, 0, 0, 32);
        finish_load("t1", 0, 1'b0);
        check_writes("t1", 0, 1'b0);

        // Offset 1 with random valid gaps
        clear_mon();
        pulse_start(1'b1);
        send_table(0, 3, 0, 32);
        finish_load("t2", 0, 1'b1);
`ifdef SYM_VN_LOADER_CHKSUM_EN
        step();
        chk("t2_err_held", {31'd0, load_err}, 32'd1);
`endif
        check_writes("t2", 0, 1'b1);
        chk("t2_offset_held", {31'd0, write_addr_offset}, 32'd1);

        // Restart while busy is ignored
        clear_mon();
        pulse_start(1'b1);
        chk("t3_err_cleared", {31'd0, load_err}, 32'd0);
        send_table(1, 0, 0, 12);
        pulse_start(1'b0);
        chk("t3_offset_kept", {31'd0, write_addr_offset}, 32'd1);
        send_table(1, 1, 12, 32);
        finish_load("t3", 1, 1'b0);
        check_writes("t3", 1, 1'b1);

        // Reset after page 7
        clear_mon();
        pulse_start(1'b1);
        send_table(2, 0, 0, 16);
        chk("t4_we_p7", {27'd0, we, page_write_addr}, {27'd1, 4'd7});
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t4_rst_outputs", {21'd0, page_write_addr, lut_in_bank0, lut_in_bank1, write_addr_offset}, 32'd0);
        chk("t4_rst_ctrl", {27'd0, we, load_busy, load_done, load_err, entry_ready}, 32'd0);
        repeat (4) step();
        chk("t4_no_done", n_done, 32'd0);
        clear_mon();
        pulse_start(1'b0);
        send_table(2, 0, 0, 32);
        finish_load("t4r", 2, 1'b0);
        check_writes("t4r", 2, 1'b0);

        // Start and valid together in IDLE: the entry is not consumed
        clear_mon();
        load_start  = 1'b1;
        load_offset = 1'b0;
        entry_in    = 3'b111;
        entry_valid = 1'b1;
        step();
        load_start  = 1'b0;
        send_table(1, 0, 0, 32);
        finish_load("t5", 1, 1'b0);
        check_writes("t5", 1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
